// File: rtl/axil_cfg_master.sv
// AXI4-Lite configuration master: issues one read or write per command and returns a
// single response. Define AXIL_CFG_TIMEOUT_EN to add a watchdog on the response wait.
module axil_cfg_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  // command
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  // response
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic [1:0]  RSP_RESP,
  output logic        RSP_TIMEOUT,
  // AXI4-Lite master
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [2:0]  M_AXI_AWPROT,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ, S_RRESP, S_REPLY
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        live_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, timeout;

  // live_q keeps CMD_READY and the B/R readies low until the first edge after reset
  assign CMD_READY    = live_q && (state_q == S_IDLE);
  assign M_AXI_BREADY = live_q && (state_q == S_IDLE || state_q == S_WRESP);
  assign M_AXI_RREADY = live_q && (state_q == S_IDLE || state_q == S_RRESP);
  assign RSP_VALID    = (state_q == S_REPLY);
  assign RSP_RDATA    = rdata_q;
  assign RSP_RESP     = resp_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_ARVALID = arvalid_q;

  assign aw_hs = awvalid_q && M_AXI_AWREADY;
  assign w_hs  = wvalid_q && M_AXI_WREADY;
  assign ar_hs = arvalid_q && M_AXI_ARREADY;
  assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;
  assign r_hs  = M_AXI_RVALID && M_AXI_RREADY;

`ifdef AXIL_CFG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;
  logic          tmo_q, tmo_d;

  // counter is zero in IDLE/REPLY, so it starts at 0 on entering WRITE or READ
  assign waiting = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                   (state_q == S_READ)  || (state_q == S_RRESP);
  assign timeout = waiting && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = waiting ? cnt_q + CW'(1) : '0;
    tmo_d = tmo_q;
    if (timeout && state_d == S_REPLY)           tmo_d = 1'b1;
    else if (state_q == S_REPLY && RSP_READY)    tmo_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign RSP_TIMEOUT = tmo_q;
`else
  // no watchdog in this build; the response wait is unbounded
  assign timeout     = 1'b0 & (TIMEOUT_CYCLES == 0);
  assign RSP_TIMEOUT = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          addr_d = CMD_ADDR + BASE_ADDR;
          if (CMD_WRITE) begin
            wdata_d   = CMD_WDATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_READ;
          end
        end
      end
      S_WRITE: begin
        // AW and W retire independently; move on once neither is still pending
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
          state_d = S_WRESP;
        end else if (timeout) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          rdata_d   = '0;
          resp_d    = 2'b10;
          state_d   = S_REPLY;
        end
      end
      S_WRESP: begin
        if (b_hs) begin
          rdata_d = '0;
          resp_d  = M_AXI_BRESP;
          state_d = S_REPLY;
        end else if (timeout) begin
          rdata_d = '0;
          resp_d  = 2'b10;
          state_d = S_REPLY;
        end
      end
      S_READ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = S_RRESP;
        end else if (timeout) begin
          arvalid_d = 1'b0;
          rdata_d   = '0;
          resp_d    = 2'b10;
          state_d   = S_REPLY;
        end
      end
      S_RRESP: begin
        if (r_hs) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = S_REPLY;
        end else if (timeout) begin
          rdata_d = '0;
          resp_d  = 2'b10;
          state_d = S_REPLY;
        end
      end
      S_REPLY: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: randomized command stream against a memory-backed AXI-Lite
// slave, with a reference memory model predicting every response.
`timescale 1ns/1ps
module tb_axil_cfg_master;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0, CMD_WDATA = '0;
  logic        RSP_VALID, RSP_READY = 1'b0, RSP_TIMEOUT;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  always #5 clk = ~clk;

  axil_cfg_master #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_RESP(RSP_RESP), .RSP_TIMEOUT(RSP_TIMEOUT),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: what each address should hold after the commands issued so far
  logic [31:0] model_mem [logic [31:0]];

  // slave side: its own storage, response code taken from address bits [5:4]
  logic [31:0] slave_mem [logic [31:0]];
  int aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
  bit r_never = 1'b0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  bit got_aw = 0, got_w = 0, got_ar = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;

  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
    M_AXI_BRESP = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
    forever begin
      @(negedge clk);
      aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
      w_hs  = M_AXI_WVALID && M_AXI_WREADY;
      b_hs  = M_AXI_BVALID && M_AXI_BREADY;
      ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
      r_hs  = M_AXI_RVALID && M_AXI_RREADY;
      if (aw_hs) begin
        aw_cnt++; s_awaddr = M_AXI_AWADDR; got_aw = 1;
        chk("awaddr", M_AXI_AWADDR, exp_addr);
        chk("awprot", M_AXI_AWPROT, 3'b000);
      end
      if (w_hs) begin
        w_cnt++; s_wdata = M_AXI_WDATA; got_w = 1;
        chk("wdata", M_AXI_WDATA, exp_wdata);
        chk("wstrb", M_AXI_WSTRB, 4'hF);
      end
      if (ar_hs) begin
        ar_cnt++; s_araddr = M_AXI_ARADDR; got_ar = 1;
        chk("araddr", M_AXI_ARADDR, exp_addr);
        chk("arprot", M_AXI_ARPROT, 3'b000);
        chk("ar_exclusive", M_AXI_AWVALID | M_AXI_WVALID, 0);
      end
      if (b_hs) b_cnt++;
      if (r_hs) r_cnt++;
      if (M_AXI_AWVALID && !aw_hs) aw_wait++;
      if (M_AXI_WVALID && !w_hs) w_wait++;
      if (M_AXI_ARVALID && !ar_hs) ar_wait++;
      if (got_aw && got_w && !M_AXI_BVALID) b_wait++;
      if (got_ar && !M_AXI_RVALID) r_wait++;
      @(posedge clk); #1;
      if (!resetn) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      end else begin
        if (aw_hs) aw_wait = 0;
        if (w_hs)  w_wait = 0;
        if (ar_hs) ar_wait = 0;
        if (b_hs) begin
          M_AXI_BVALID = 0; slave_mem[s_awaddr] = s_wdata; got_aw = 0; got_w = 0; b_wait = 0;
        end
        if (r_hs) begin M_AXI_RVALID = 0; got_ar = 0; r_wait = 0; end
        M_AXI_AWREADY = (aw_wait >= aw_dly);
        M_AXI_WREADY  = (w_wait >= w_dly);
        M_AXI_ARREADY = (ar_wait >= aw_dly);
        if (got_aw && got_w && !M_AXI_BVALID && b_wait >= b_dly) begin
          M_AXI_BVALID = 1; M_AXI_BRESP = s_awaddr[5:4];
        end
        if (got_ar && !M_AXI_RVALID && !r_never && r_wait >= r_dly) begin
          M_AXI_RVALID = 1;
          M_AXI_RDATA  = slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : ~s_araddr;
          M_AXI_RRESP  = s_araddr[5:4];
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    exp_addr = a + BASE; exp_wdata = d;
    @(posedge clk); #1;
    CMD_VALID = 1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d;
    n = 0;
    @(negedge clk);
    while (!CMD_READY && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready", CMD_READY, 1);
    @(posedge clk); #1;
    CMD_VALID = 0; CMD_WRITE = 1'($urandom_range(0, 1));
    CMD_ADDR = $urandom; CMD_WDATA = $urandom;
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int adly, input int wdly, input int rspd, input int hold,
                        input bit chk_lat);
    logic [31:0] fa, erd, s_rd;
    logic [1:0]  ers, s_rs;
    int lat;
    bit busy, stable;
    fa  = a + BASE;
    ers = fa[5:4];
    if (wr) begin erd = '0; model_mem[fa] = d; end
    else erd = model_mem.exists(fa) ? model_mem[fa] : ~fa;
    aw_dly = adly; w_dly = wdly; b_dly = rspd; r_dly = rspd;
    issue(wr, a, d);
    lat = 0; busy = 0;
    do begin
      @(negedge clk); lat++;
      if (CMD_READY) busy = 1;
    end while (!RSP_VALID && lat < 200);
    chk("rsp_valid", RSP_VALID, 1);
    if (chk_lat) chk("latency", lat, 3);
    chk("busy_cmd_ready", busy, 0);
    chk("rsp_rdata", RSP_RDATA, erd);
    chk("rsp_resp", RSP_RESP, ers);
    chk("rsp_timeout", RSP_TIMEOUT, 0);
    chk("aw_count", aw_cnt, wr ? 1 : 0);
    chk("w_count", w_cnt, wr ? 1 : 0);
    chk("b_count", b_cnt, wr ? 1 : 0);
    chk("ar_count", ar_cnt, wr ? 0 : 1);
    chk("r_count", r_cnt, wr ? 0 : 1);
    s_rd = RSP_RDATA; s_rs = RSP_RESP; stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!RSP_VALID || RSP_RDATA !== s_rd || RSP_RESP !== s_rs || CMD_READY) stable = 0;
    end
    chk("hold_stable", stable, 1);
    @(posedge clk); #1; RSP_READY = 1;
    @(posedge clk); #1; RSP_READY = 0;
    @(negedge clk);
    chk("back_to_idle", {RSP_VALID, CMD_READY}, 2'b01);
  endtask

  task automatic reset_mid_wresp();
    int n;
    bit ok, seen;
    aw_dly = 0; w_dly = 0; b_dly = 40;
    issue(1'b1, 32'h800, $urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!(aw_cnt == 1 && w_cnt == 1) && n < 50);
    @(negedge clk);
    chk("wresp_state", {M_AXI_BREADY, CMD_READY, RSP_VALID}, 3'b100);
    resetn = 0;
    #1;
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, RSP_VALID, CMD_READY} !== 5'b0) ok = 0;
      @(negedge clk);
    end
    chk("valids_in_reset", ok, 1);
    @(posedge clk); #1; resetn = 1;
    @(negedge clk); chk("rdy_before_edge", CMD_READY, 0);
    @(negedge clk); chk("rdy_after_edge", CMD_READY, 1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (RSP_VALID) seen = 1; end
    chk("no_rsp_after_abort", seen, 0);
    chk("no_b_after_abort", b_cnt, 0);
  endtask

  task automatic no_rvalid_test();
    int n;
    r_never = 1; aw_dly = 0;
    issue(1'b0, 32'h40, '0);
    n = 0;
    do begin @(negedge clk); n++; end while (!RSP_VALID && n < 80);
`ifdef AXIL_CFG_TIMEOUT_EN
    chk("tmo_rsp_valid", RSP_VALID, 1);
    chk("tmo_resp", RSP_RESP, 2'b10);
    chk("tmo_flag", RSP_TIMEOUT, 1);
    chk("tmo_rdata", RSP_RDATA, 0);
    chk("tmo_arvalid", M_AXI_ARVALID, 0);
    @(posedge clk); #1; RSP_READY = 1;
    @(posedge clk); #1; RSP_READY = 0;
    @(negedge clk);
    chk("tmo_cleared", {RSP_VALID, RSP_TIMEOUT, CMD_READY}, 3'b001);
`else
    chk("wait_forever", RSP_VALID, 0);
    chk("still_waiting", {M_AXI_RREADY, CMD_READY, RSP_TIMEOUT}, 3'b100);
`endif
    @(posedge clk); #1; resetn = 0; r_never = 0;
    @(posedge clk); @(posedge clk); #1; resetn = 1;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    bit wr;
    logic [31:0] a, d;
    int ad, wd, rd, hd;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", CMD_READY, 0);
    chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, RSP_VALID, RSP_TIMEOUT}, 5'b0);
    chk("rst_readies", {M_AXI_BREADY, M_AXI_RREADY}, 2'b00);
    chk("rst_rdata", RSP_RDATA, 0);
    chk("rst_resp", RSP_RESP, 0);
    @(posedge clk); #1; resetn = 1;
    @(negedge clk); chk("rdy_pre_edge", CMD_READY, 0);
    @(negedge clk); chk("rdy_post_edge", CMD_READY, 1);
    chk("idle_readies", {M_AXI_BREADY, M_AXI_RREADY}, 2'b11);

    do_txn(1'b1, 32'h8, 32'hDEADBEEF, 0, 0, 0, 0, 1'b1);
    do_txn(1'b1, 32'h30, 32'h12345678, 0, 0, 0, 0, 1'b1);
    do_txn(1'b0, 32'h30, '0, 0, 0, 0, 0, 1'b1);
    do_txn(1'b1, 32'h14, 32'hA5A5_0001, 4, 0, 1, 0, 1'b0);
    do_txn(1'b1, 32'h18, 32'h5A5A_0002, 0, 4, 1, 0, 1'b0);
    do_txn(1'b0, 32'h8, '0, 2, 0, 2, 10, 1'b0);
    do_txn(1'b1, 32'hFFFF_F004, 32'h0BAD_F00D, 0, 0, 0, 3, 1'b1);
    do_txn(1'b0, 32'hFFFF_F004, '0, 1, 0, 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_F000 + 32'($urandom_range(0, 7)) * 4;
      else a = 32'($urandom_range(0, 15)) * 4;
      d  = $urandom;
      ad = int'($urandom_range(0, 3));
      wd = int'($urandom_range(0, 3));
      rd = int'($urandom_range(0, 3));
      hd = int'($urandom_range(0, 3));
      do_txn(wr, a, d, ad, wd, rd, hd, (ad == 0 && wd == 0 && rd == 0));
    end

    reset_mid_wresp();
    do_txn(1'b0, 32'h8, '0, 0, 0, 0, 0, 1'b1);
    no_rvalid_test();
    do_txn(1'b0, 32'h30, '0, 0, 0, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axil_cfg_master.md
AXIL_CFG_MASTER -- requirements
Module: axil_cfg_master

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0, meaning an offset added (mod 2^32) to every command address.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the response wait limit when the timeout feature is compiled in.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Command port SHALL be: CMD_VALID in 1, CMD_READY out 1, CMD_WRITE in 1 (1=write, 0=read), CMD_ADDR in 32, CMD_WDATA in 32.
REQ-006 Response port SHALL be: RSP_VALID out 1, RSP_READY in 1, RSP_RDATA out 32, RSP_RESP out 2 (AXI code), RSP_TIMEOUT out 1.
REQ-007 AXI4-Lite master port SHALL be M_AXI_AW{ADDR 32, VALID, READY, PROT 3}, M_AXI_W{DATA 32, STRB 4, VALID, READY}, M_AXI_B{RESP 2, VALID, READY}, M_AXI_AR{ADDR 32, VALID, READY, PROT 3}, M_AXI_R{DATA 32, RESP 2, VALID, READY}.

Function
REQ-008 The block SHALL have states IDLE, WRITE, WRESP, READ, RRESP, REPLY, and one transaction outstanding at most.
REQ-009 CMD_READY SHALL be 1 only in IDLE; a command is accepted on the cycle CMD_VALID & CMD_READY.
REQ-010 On accepting a write, the block SHALL register address (CMD_ADDR+BASE_ADDR) and data, then assert AWVALID and WVALID together on the next cycle, entering WRITE.
REQ-011 In WRITE, AWVALID and WVALID SHALL each drop independently on their own handshake; the block SHALL enter WRESP once both handshakes are complete, in either order or the same cycle.
REQ-012 On accepting a read, the block SHALL assert ARVALID the next cycle in READ, and enter RRESP after the AR handshake.
REQ-013 BREADY SHALL be 1 in WRESP and IDLE; RREADY SHALL be 1 in RRESP and IDLE; B/R beats arriving in IDLE SHALL be discarded.
REQ-014 On the B or R handshake, the block SHALL capture RESP (and RDATA for reads; RDATA=0 for writes), then enter REPLY with RSP_VALID=1 on the following cycle.
REQ-015 RSP_VALID and the response fields SHALL hold stable until RSP_READY; on RSP_VALID & RSP_READY the block SHALL return to IDLE.
REQ-016 WSTRB SHALL be 4'hF; AWPROT and ARPROT SHALL be 3'b000.
REQ-017 Command-to-response minimum latency SHALL be 3 cycles when the slave responds with zero wait states (accept, address/data handshake, response capture, RSP_VALID).
REQ-018 Address addition SHALL wrap at 32 bits without error.

Reset
REQ-019 With resetn low, the state SHALL be IDLE; CMD_READY SHALL be 0 while reset is asserted; all AXI VALIDs, RSP_VALID, and RSP_TIMEOUT SHALL be 0; RSP_RDATA and RSP_RESP SHALL be 0; BREADY and RREADY SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL abandon it immediately with no response issued; CMD_READY SHALL rise on the first clock edge after resetn deasserts.

Configuration
REQ-021 Macro AXIL_CFG_TIMEOUT_EN SHALL, when defined, add a counter that starts at 0 on entering WRITE or READ and clears on leaving RRESP or WRESP.
REQ-022 With AXIL_CFG_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES before the B/R handshake, the block SHALL drop all AXI VALIDs, enter REPLY with RSP_RESP=2'b10, RSP_RDATA=0 and RSP_TIMEOUT=1.
REQ-023 Without AXIL_CFG_TIMEOUT_EN, no counter SHALL exist, RSP_TIMEOUT SHALL be tied 0, and the block SHALL wait indefinitely.

Verification
REQ-024 Write: BASE_ADDR=32'h1000, cmd write addr 8 data 32'hDEADBEEF -> AWADDR=32'h1008, WDATA=32'hDEADBEEF, STRB=F, then RSP_RESP=0, RSP_RDATA=0.
REQ-025 Read with slave RDATA=32'h12345678, RRESP=3 -> RSP_RDATA=32'h12345678, RSP_RESP=3, RSP_TIMEOUT=0.
REQ-026 WREADY given 4 cycles before AWREADY, and vice versa -> exactly one AW and one W handshake each, then a single B accepted.
REQ-027 RSP_READY held low 10 cycles -> RSP_VALID and fields stable, CMD_READY=0 throughout.
REQ-028 Reset pulsed during WRESP -> all VALIDs 0 while reset is asserted, no response issued, CMD_READY=1 on the first clock edge after release.
REQ-029 AXIL_CFG_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave never asserts RVALID -> RSP_VALID with RSP_RESP=2, RSP_TIMEOUT=1, ARVALID low.
